pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised program-counter generator for the pipelined CPU; successor to the single-register PC.
- Adds a start/halt state machine, sequential increment and branch/jump redirect.
- Redirects that arrive during a hazard stall are buffered and applied on stall release, so none are lost.
- Sits at the head of IF; pc_o drives instruction memory and the PC+STEP adder path.

Parameters:
- WIDTH, 32, PC and target width in bits.
- RESET_VEC, 0, PC value after reset and while idle.
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits that must be zero (used only by the optional feature).
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned redirect (used only by the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  level; IDLE->RUN or HALT->RUN.
- halt_i  in  1  stop fetch; RUN->HALT.
- stall_i  in  1  hazard-detect stall; hold PC.
- redirect_i  in  1  branch/jump taken this cycle.
- target_i  in  WIDTH  redirect target address.
- pc_o  out  WIDTH  current fetch address.
- valid_o  out  1  pc_o is a live fetch address.
- pend_o  out  1  buffered redirect waiting for stall release.
- misalign_o  out  1  one-cycle pulse on trapped redirect (optional feature).

Behaviour:
- Reset (rst_n_i=0, takes effect immediately, independent of clk_i):
  - state=IDLE; pc_o=RESET_VEC.
  - valid_o=0, pend_o=0, misalign_o=0; pending target register=0.
- IDLE:
  - pc_o held at RESET_VEC; valid_o=0; all other inputs ignored.
  - start_i=1 at posedge -> RUN; valid_o=1 from the next cycle; pc_o stays RESET_VEC, so the first fetch is RESET_VEC.
- RUN, evaluated each posedge in priority order:
  1. halt_i=1 -> HALT; valid_o=0; pc_o held; pend_o cleared.
  2. stall_i=0 and redirect_i=1 -> pc_o<=target_i; pend_o<=0. A new redirect beats a pending one.
  3. stall_i=0 and pend_o=1 -> pc_o<=pending target; pend_o<=0.
  4. stall_i=0 otherwise -> pc_o<=pc_o+STEP, modulo 2^WIDTH; the all-ones region wraps to 0 with no flag.
  5. stall_i=1 -> pc_o held. If redirect_i=1, pending target<=target_i and pend_o<=1. A later redirect during the same stall overwrites the buffer; only the newest is kept.
- HALT:
  - pc_o held; valid_o=0; redirect_i and stall_i ignored.
  - start_i=1 -> RUN; valid_o=1 next cycle; fetch resumes at the held pc_o.
- start_i in RUN is ignored.
- Latency: every pc_o update is visible one cycle after the qualifying edge. No combinational path from any input to pc_o.
- Reset mid-stall with a redirect pending: the pending redirect is discarded and the state returns to IDLE.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined: when a redirect is applied (rule 2, or rule 3 on the stored target) and target[ALIGN_BITS-1:0]!=0:
  - pc_o<=TRAP_VEC instead of the target.
  - misalign_o=1 for exactly one cycle; pend_o cleared.
  - Check is made at apply time, not at buffer time.
- Not defined: targets are loaded unchanged, including low bits; misalign_o tied 0; TRAP_VEC and ALIGN_BITS unused.

Test Plan:
- Reset, hold start_i=0 10 cycles -> pc_o=0, valid_o=0 throughout. Pulse start_i -> pc_o sequence 0,0,4,8,12 with valid_o=1 from the 2nd value.
- RUN at pc 0x10, stall_i=1 3 cycles -> pc_o stays 0x10. Release -> 0x14.
- RUN at pc 0x20, stall_i=1; redirect_i=1, target 0x80 in stall cycle 1, then target 0x90 in stall cycle 2 -> pend_o=1, pc_o=0x20 held. Release -> pc_o=0x90, pend_o=0, then 0x94.
- Stall releases in the same cycle as redirect target 0x200 while 0x80 is pending -> pc_o=0x200, pend_o=0.
- WIDTH=8, pc_o=0xFC, no stall -> pc_o=0x00. halt_i=1 -> valid_o=0, pc_o frozen. start_i -> resumes at frozen value. Assert rst_n_i mid-cycle -> pc_o=RESET_VEC immediately.
- With PC_ALIGN_CHK_EN, redirect target 0x42 -> pc_o=0x100, misalign_o high exactly 1 cycle. Without the macro -> pc_o=0x42, misalign_o=0.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator at the head of the IF stage.
//
// A start/halt state machine gates fetch. While running, the PC either
// steps by STEP, loads a branch/jump target, or holds during a hazard stall.
// A redirect that arrives during a stall is buffered and applied when the
// stall releases, so that no redirect is lost. Every output is registered,
// so there is no combinational path from any input to pc_o.
//
// Optional feature (compile-time macro PC_ALIGN_CHK_EN):
//   A redirect whose low ALIGN_BITS bits are non-zero loads TRAP_VEC instead
//   of the target and pulses misalign_o for one cycle. The check is made
//   when the redirect is applied, not when it is buffered. When the macro is
//   undefined, targets load unchanged and misalign_o is tied low.
//
// Parameters:
//   WIDTH      PC / target width in bits
//   RESET_VEC  PC value after reset and while idle
//   STEP       sequential increment in bytes
//   ALIGN_BITS low target bits that must be zero (alignment check only)
//   TRAP_VEC   PC loaded on a misaligned redirect (alignment check only)
//
// Ports:
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   start_i     IDLE->RUN or HALT->RUN
//   halt_i      RUN->HALT, stops fetch
//   stall_i     hazard stall, holds the PC
//   redirect_i  branch/jump taken this cycle
//   target_i    redirect target address
//   pc_o        current fetch address
//   valid_o     pc_o is a live fetch address
//   pend_o      a buffered redirect is waiting for the stall to release
//   misalign_o  one-cycle pulse on a trapped redirect

module pc_gen #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter int unsigned      STEP       = 4,
  parameter int unsigned      ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] TRAP_VEC   = WIDTH'(32'h0000_0100)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             valid_o,
  output logic             pend_o,
  output logic             misalign_o
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  // Elaboration-time sanity checks on the configuration.
  if (ALIGN_BITS == 0 || ALIGN_BITS >= WIDTH) begin : g_bad_align
    $error("pc_gen: ALIGN_BITS must be in 1..WIDTH-1");
  end
  if ((TRAP_VEC & ALIGN_MASK) != '0) begin : g_bad_trap
    $error("pc_gen: TRAP_VEC must itself be aligned");
  end
  if ((RESET_VEC & ALIGN_MASK) != '0) begin : g_bad_reset
    $error("pc_gen: RESET_VEC must itself be aligned");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_nx;
  logic [WIDTH-1:0] pend_tgt;
  logic [WIDTH-1:0] pend_tgt_nx;
  logic             valid;
  logic             valid_nx;
  logic             pend;
  logic             pend_nx;
  logic             apply;
  logic [WIDTH-1:0] apply_tgt;
  logic             mis_nx;

  // Register stage: all visible outputs come straight from flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      pc       <= RESET_VEC;
      pend_tgt <= '0;
      valid    <= 1'b0;
      pend     <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      pend_tgt <= pend_tgt_nx;
      valid    <= valid_nx;
      pend     <= pend_nx;
    end
  end

  // Next-state logic. The RUN branch encodes the priority
  // halt > redirect > pending redirect > step, with the stall case
  // only buffering.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    pend_tgt_nx = pend_tgt;
    pend_nx     = pend;
    apply       = 1'b0;
    apply_tgt   = target_i;
    mis_nx      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) state_nx = RUN;
      end
      RUN: begin
        if (halt_i) begin
          state_nx = HALT;
          pend_nx  = 1'b0;
        end else if (!stall_i) begin
          pend_nx = 1'b0;
          if (redirect_i) begin
            apply     = 1'b1;
            apply_tgt = target_i;
          end else if (pend) begin
            apply     = 1'b1;
            apply_tgt = pend_tgt;
          end else begin
            pc_nx = pc + STEP_W;
          end
        end else if (redirect_i) begin
          // Only the newest redirect of a stall is kept.
          pend_nx     = 1'b1;
          pend_tgt_nx = target_i;
        end
      end
      HALT: begin
        if (start_i) state_nx = RUN;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (apply) begin
`ifdef PC_ALIGN_CHK_EN
      if ((apply_tgt & ALIGN_MASK) != '0) begin
        pc_nx  = TRAP_VEC;
        mis_nx = 1'b1;
      end else begin
        pc_nx = apply_tgt;
      end
`else
      pc_nx = apply_tgt;
`endif
    end

    valid_nx = (state_nx == RUN);
  end

`ifdef PC_ALIGN_CHK_EN
  logic mis;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mis <= 1'b0;
    end else begin
      mis <= mis_nx;
    end
  end

  assign misalign_o = mis;
`else
  // Without the alignment check there is never a trap to report.
  logic unused_mis;
  assign unused_mis = mis_nx;
  assign misalign_o = 1'b0;
`endif

  assign pc_o    = pc;
  assign valid_o = valid;
  assign pend_o  = pend;

endmodule
